// File: rtl/pipe_ctrl_n_pkg.sv
// Shared definitions for the parametrised pipeline stall/flush controller.
package pipe_ctrl_pkg;

  typedef enum logic [0:0] {
    IDLE      = 1'b0,
    WAIT_SLOT = 1'b1
  } state_t;

  localparam int STAGES_DEF  = 6;
  localparam int MAX_OUT_DEF = 4;

endpackage

// File: rtl/pipe_ctrl_n_if.sv
// Datapath-facing bundle of the pipeline controller: stage status and fetch
// handshakes in, per-stage hold/bubble/kill and fetch control out.
interface pipe_ctrl_n_if
  import pipe_ctrl_pkg::*;
#(
  parameter int STAGES = STAGES_DEF,
  parameter int SW     = 3
);
  logic [STAGES-1:0] stage_valid;
  logic [STAGES-1:0] stall_req;
  logic              flush_valid;
  logic [SW-1:0]     flush_stage;
  logic              flush_self;
  logic              flush_keep_slot;
  logic              if_req_fire;
  logic              if_resp_fire;
  logic [STAGES-1:0] hold;
  logic [STAGES-1:0] bubble;
  logic [STAGES-1:0] kill;
  logic              pc_hold;
  logic              redirect_fire;
  logic              drop_resp;
  logic              busy;

  modport master (
    output stage_valid, stall_req, flush_valid, flush_stage, flush_self,
           flush_keep_slot, if_req_fire, if_resp_fire,
    input  hold, bubble, kill, pc_hold, redirect_fire, drop_resp, busy
  );

  modport slave (
    input  stage_valid, stall_req, flush_valid, flush_stage, flush_self,
           flush_keep_slot, if_req_fire, if_resp_fire,
    output hold, bubble, kill, pc_hold, redirect_fire, drop_resp, busy
  );
endinterface

// File: rtl/pipe_ctrl_n_fetch_track.sv
// Outstanding instruction-fetch tracker; marks responses that belong to
// requests issued before the last flush as stale.
module fetch_track
  import pipe_ctrl_pkg::*;
#(
  parameter int MAX_OUT = MAX_OUT_DEF,
  parameter int OW      = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          if_req_fire,
  input  logic          if_resp_fire,
  input  logic          commit,
  output logic [OW-1:0] out_cnt,
  output logic          drop_resp
);
  localparam logic [OW-1:0] MAX_CNT = OW'(MAX_OUT);

  logic [OW-1:0] disc_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_cnt  <= '0;
      disc_cnt <= '0;
    end else begin
      if (if_req_fire && !if_resp_fire && out_cnt != MAX_CNT)
        out_cnt <= out_cnt + 1'b1;
      else if (if_resp_fire && !if_req_fire && out_cnt != '0)
        out_cnt <= out_cnt - 1'b1;

      // a response landing in the commit cycle is already killed in stage 0
      if (commit)
        disc_cnt <= (if_resp_fire && out_cnt != '0) ? out_cnt - 1'b1 : out_cnt;
      else if (if_resp_fire && disc_cnt != '0)
        disc_cnt <= disc_cnt - 1'b1;
    end
  end

  assign drop_resp = (disc_cnt != '0);

endmodule

// File: rtl/pipe_ctrl_n.sv
// Pipeline stall/flush controller for an N-stage core; optional performance
// counters are enabled by defining PIPE_PERF_CNT_EN.
//   state     | meaning
//   IDLE      | no flush pending; flushes commit immediately
//   WAIT_SLOT | delay-slot flush latched, waiting for the slot to be fetched
module pipe_ctrl_n
  import pipe_ctrl_pkg::*;
#(
  parameter int STAGES  = STAGES_DEF,
  parameter int SW      = 3,
  parameter int MAX_OUT = MAX_OUT_DEF,
  parameter int OW      = 3
) (
  input  logic         clk,
  input  logic         rst,
  pipe_ctrl_n_if.slave bus
`ifdef PIPE_PERF_CNT_EN
  ,
  output logic [31:0]  stall_cycles,
  output logic [31:0]  flush_count,
  output logic [31:0]  drop_count
`endif
);
  state_t            state, state_nxt;
  logic              slot_arrived, slot_arrived_nxt;
  logic [SW-1:0]     lat_stage, lat_stage_nxt;
  logic              lat_self, lat_self_nxt;
  logic [STAGES-1:0] hold_raw, bubble_raw, imm_kill, def_kill, kill;
  logic              slot_found;
  logic [SW-1:0]     slot_idx;
  logic              flush_ok, commit, drop_resp;
  logic [OW-1:0]     out_cnt;

  assign flush_ok = bus.flush_valid &&
                    ({1'b0, bus.flush_stage} < (SW+1)'(STAGES));

  // empty stages absorb stalls coming from downstream
  always_comb begin
    hold_raw   = '0;
    bubble_raw = '0;
    hold_raw[STAGES-1] = bus.stall_req[STAGES-1];
    for (int k = STAGES-2; k >= 0; k--)
      hold_raw[k] = bus.stall_req[k] | (hold_raw[k+1] & bus.stage_valid[k+1]);
    for (int k = 1; k < STAGES; k++)
      bubble_raw[k] = hold_raw[k-1] & ~hold_raw[k];
  end

  always_comb begin
    slot_found = 1'b0;
    slot_idx   = '0;
    imm_kill   = '0;
    def_kill   = '0;
    for (int k = 0; k < STAGES; k++)
      if (k < int'(bus.flush_stage) && bus.stage_valid[k]) begin
        slot_found = 1'b1;
        slot_idx   = SW'(k);
      end
    for (int k = 0; k < STAGES; k++) begin
      imm_kill[k] = (k < int'(bus.flush_stage)) ||
                    (k == int'(bus.flush_stage) && bus.flush_self);
      if (bus.flush_keep_slot && slot_found && slot_idx == SW'(k))
        imm_kill[k] = 1'b0;
      // deferred commit: the slot has just entered stage 0 and survives
      def_kill[k] = (k >= 1 && k < int'(lat_stage)) ||
                    (k == int'(lat_stage) && lat_self);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      slot_arrived <= 1'b0;
      lat_stage    <= '0;
      lat_self     <= 1'b0;
    end else begin
      state        <= state_nxt;
      slot_arrived <= slot_arrived_nxt;
      lat_stage    <= lat_stage_nxt;
      lat_self     <= lat_self_nxt;
    end
  end

  always_comb begin
    state_nxt        = state;
    slot_arrived_nxt = slot_arrived;
    lat_stage_nxt    = lat_stage;
    lat_self_nxt     = lat_self;
    kill             = '0;
    commit           = 1'b0;
    case (state)
      IDLE: begin
        if (flush_ok) begin
          if (!bus.flush_keep_slot || slot_found) begin
            kill   = imm_kill;
            commit = 1'b1;
          end else begin
            state_nxt        = WAIT_SLOT;
            lat_stage_nxt    = bus.flush_stage;
            lat_self_nxt     = bus.flush_self;
            slot_arrived_nxt = 1'b0;
          end
        end
      end
      WAIT_SLOT: begin
        if (flush_ok && bus.flush_self) begin
          kill             = imm_kill;
          commit           = 1'b1;
          state_nxt        = IDLE;
          slot_arrived_nxt = 1'b0;
        end else if (slot_arrived) begin
          kill             = def_kill;
          commit           = 1'b1;
          state_nxt        = IDLE;
          slot_arrived_nxt = 1'b0;
        end else if (bus.if_resp_fire && !drop_resp) begin
          slot_arrived_nxt = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  fetch_track #(.MAX_OUT(MAX_OUT), .OW(OW)) u_fetch_track (
    .clk          (clk),
    .rst          (rst),
    .if_req_fire  (bus.if_req_fire),
    .if_resp_fire (bus.if_resp_fire),
    .commit       (commit),
    .out_cnt      (out_cnt),
    .drop_resp    (drop_resp)
  );

  assign bus.kill          = kill;
  assign bus.hold          = hold_raw & ~kill;
  assign bus.bubble        = bubble_raw & ~kill;
  assign bus.pc_hold       = bus.hold[0] | (out_cnt == OW'(MAX_OUT)) | (state == WAIT_SLOT);
  assign bus.redirect_fire = commit;
  assign bus.drop_resp     = drop_resp;
  assign bus.busy          = (state != IDLE);

`ifdef PIPE_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cycles <= '0;
      flush_count  <= '0;
      drop_count   <= '0;
    end else begin
      stall_cycles <= stall_cycles + {31'd0, bus.hold[0]};
      flush_count  <= flush_count + {31'd0, commit};
      drop_count   <= drop_count + {31'd0, bus.if_resp_fire & drop_resp};
    end
  end
`endif

endmodule
